// File: rtl/scv_timing_gen.sv
// Master timing source for the SCV core: four rotating CPU phase enables, video
// counters and blanking flags. Define SCV_TIMING_FRAME_CNT_EN to build the frame counter.
module scv_timing_gen #(
  parameter int LINE_CYC  = 512,
  parameter int HBL_START = 416,
  parameter int LINES     = 262,
  parameter int VBL_START = 240
) (
  input  logic                        CLK,
  input  logic                        RES,
  input  logic                        HOLD,
  output logic                        CP1_POSEDGE,
  output logic                        CP1_NEGEDGE,
  output logic                        CP2_POSEDGE,
  output logic                        CP2_NEGEDGE,
  output logic [$clog2(LINE_CYC)-1:0] HPOS,
  output logic [$clog2(LINES)-1:0]    VPOS,
  output logic                        HBL,
  output logic                        VBL,
  output logic [7:0]                  FRAME_CNT
);

  localparam int HW = $clog2(LINE_CYC);
  localparam int VW = $clog2(LINES);

  localparam logic [HW-1:0] H_LAST  = HW'(LINE_CYC - 1);
  localparam logic [HW-1:0] H_START = HW'(HBL_START);
  localparam logic [VW-1:0] V_LAST  = VW'(LINES - 1);
  localparam logic [VW-1:0] V_START = VW'(VBL_START);

  logic [1:0] ph;
  logic [3:0] cp;

  // Phase enables are registered from ph, so the first edge after reset gives CP1_POSEDGE.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ph <= 2'd0;
      cp <= 4'b0000;
    end else begin
      cp <= 4'b0001 << ph;
      ph <= ph + 2'd1;
    end
  end

  assign CP1_POSEDGE = cp[0];
  assign CP1_NEGEDGE = cp[1];
  assign CP2_POSEDGE = cp[2];
  assign CP2_NEGEDGE = cp[3];

  logic [HW-1:0] hpos_nxt;
  logic [VW-1:0] vpos_nxt;
  logic          line_end;
  logic          frame_end;

  assign line_end  = (HPOS == H_LAST);
  assign frame_end = line_end && (VPOS == V_LAST);

  always_comb begin
    hpos_nxt = HPOS;
    vpos_nxt = VPOS;
    if (!HOLD) begin
      if (line_end) begin
        hpos_nxt = '0;
        vpos_nxt = (VPOS == V_LAST) ? '0 : VPOS + VW'(1);
      end else begin
        hpos_nxt = HPOS + HW'(1);
      end
    end
  end

  // Blanking flags are derived from the next counter values so they line up with HPOS/VPOS.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      HPOS <= '0;
      VPOS <= '0;
      HBL  <= 1'b0;
      VBL  <= 1'b0;
    end else begin
      HPOS <= hpos_nxt;
      VPOS <= vpos_nxt;
      HBL  <= (hpos_nxt >= H_START);
      VBL  <= (vpos_nxt >= V_START);
    end
  end

`ifdef SCV_TIMING_FRAME_CNT_EN
  logic [7:0] frame_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      frame_q <= 8'h00;
    end else if (!HOLD && frame_end) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign FRAME_CNT = frame_q;
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
  assign FRAME_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_scv_timing_gen.sv
// Self-checking bench for scv_timing_gen with a small line/frame geometry.
// Expected outputs come from an edge/time-count model pushed to a queue per cycle.
module tb_scv_timing_gen;

  localparam int LC = 8;
  localparam int HS = 6;
  localparam int LN = 6;
  localparam int VS = 4;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic       HOLD = 1'b0;
  logic       CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE;
  logic [2:0] HPOS;
  logic [2:0] VPOS;
  logic       HBL, VBL;
  logic [7:0] FRAME_CNT;

  scv_timing_gen #(
    .LINE_CYC (LC),
    .HBL_START(HS),
    .LINES    (LN),
    .VBL_START(VS)
  ) dut (
    .CLK        (CLK),
    .RES        (RES),
    .HOLD       (HOLD),
    .CP1_POSEDGE(CP1_POSEDGE),
    .CP1_NEGEDGE(CP1_NEGEDGE),
    .CP2_POSEDGE(CP2_POSEDGE),
    .CP2_NEGEDGE(CP2_NEGEDGE),
    .HPOS       (HPOS),
    .VPOS       (VPOS),
    .HBL        (HBL),
    .VBL        (VBL),
    .FRAME_CNT  (FRAME_CNT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard
  int n_vec  = 0;
  int n_miss = 0;
  logic [19:0] exp_q[$];

  // model: edges since reset release, and edges on which the counters advanced
  int m_edges = 0;
  int m_t     = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d (edges=%0d t=%0d)",
               tag, $time, got, exp, m_edges, m_t);
    end
  endtask

  function automatic logic [19:0] model_out();
    logic [3:0] cp;
    int hp, vp;
    logic [7:0] fc;
    cp = (m_edges == 0) ? 4'b0000 : (4'b0001 << ((m_edges - 1) % 4));
    hp = m_t % LC;
    vp = (m_t / LC) % LN;
`ifdef SCV_TIMING_FRAME_CNT_EN
    fc = 8'((m_t / (LC * LN)) % 256);
`else
    fc = 8'h00;
`endif
    return {cp, 3'(hp), 3'(vp), (hp >= HS), (vp >= VS), fc};
  endfunction

  task automatic check_dut(input logic [19:0] e);
    logic [3:0] cp;
    cp = {CP2_NEGEDGE, CP2_POSEDGE, CP1_NEGEDGE, CP1_POSEDGE};
    check_val("cp", 32'(cp), 32'(e[19:16]));
    check_val("hpos", 32'(HPOS), 32'(e[15:13]));
    check_val("vpos", 32'(VPOS), 32'(e[12:10]));
    check_val("hbl", 32'(HBL), 32'(e[9]));
    check_val("vbl", 32'(VBL), 32'(e[8]));
    check_val("frame_cnt", 32'(FRAME_CNT), 32'(e[7:0]));
    if (m_edges > 0) check_val("cp_onehot", 32'($countones(cp)), 32'd1);
  endtask

  // driver: one clock with the given HOLD value
  task automatic step(input logic h);
    logic [19:0] e;
    HOLD = h;
    m_edges++;
    if (!h) m_t++;
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL queue_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_dut(e);
    end
  endtask

  // async reset: outputs must clear before any clock edge, then stay clear
  task automatic do_reset(input int cycles);
    RES = 1'b1;
    HOLD = 1'b0;
    m_edges = 0;
    m_t = 0;
    #1;
    check_dut(model_out());
    repeat (cycles) begin
      @(posedge CLK);
      #1;
      check_dut(model_out());
    end
    RES = 1'b0;
  endtask

  initial begin
    #2;
    do_reset(3);

    // phase rotation, horizontal and vertical timing over two frames
    repeat (100) step(1'b0);

    // random HOLD insertion
    repeat (200) step($urandom_range(0, 3) == 0);

    // HOLD across the last cycle of a frame
    while ((m_t % (LC * LN)) != (LC * LN - 1)) step(1'b0);
    repeat (5) step(1'b1);
    step(1'b0);

    // mid-frame reset while VBL is high
    while (!(((m_t / LC) % LN) == VS && (m_t % LC) == 3)) step(1'b0);
    #2;
    do_reset(2);
    repeat (100) step(1'b0);

    // long run through the 8-bit frame counter wrap
    #2;
    do_reset(1);
    while (m_t < 256 * LC * LN + 2) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
